// File: rtl/pulse_counter_pkg.sv
// pulse_counter_pkg: shared BCD digit type, control states and integer-to-BCD conversion.
package pulse_counter_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, STEP, REPORT} state_t;
  function automatic logic [31:0] to_bcd(input int unsigned value);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/pulse_bcd_counter_if.sv
// pulse_bcd_counter_if: step requests in, packed BCD count and status flags out.
interface pulse_bcd_counter_if #(parameter int Digits = 4) ();
  logic up;
  logic down;
  logic [4*Digits-1:0] digits;
  logic at_max;
  logic at_min;
  logic changed;
  modport master (output up, down, input digits, at_max, at_min, changed);
  modport slave (input up, down, output digits, at_max, at_min, changed);
endinterface

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit incremented or decremented under carry/borrow in.
module bcd_digit_step
  import pulse_counter_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);
  logic roll;
  always_comb begin
    roll = up ? d == 4'd9 : d == 4'd0;
    cout = cin & roll;
    q = !cin ? d : roll ? (up ? 4'd0 : 4'd9) : up ? d + 4'd1 : d - 4'd1;
  end
endmodule

// File: rtl/pulse_bcd_counter.sv
// pulse_bcd_counter: edge-triggered up/down BCD counter with saturate or wrap limits.
module pulse_bcd_counter
  import pulse_counter_pkg::*;
#(
  parameter int Digits    = 4,
  parameter int MinValue  = 0,
  parameter int MaxValue  = 9999,
  parameter int Wrap      = 0,
  parameter int InitValue = 0
) (
  input logic clk,
  input logic rst_n,
  pulse_bcd_counter_if.slave bus
);
  localparam int W = 4 * Digits;
  localparam int LIMIT = 10 ** Digits - 1;
  localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MinValue));
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MaxValue));
  localparam logic [W-1:0] INIT_BCD = W'(to_bcd(InitValue));
  if (MinValue >= MaxValue || MaxValue > LIMIT || InitValue < MinValue || InitValue > MaxValue) begin : g_bad_params
    $fatal(1, "pulse_bcd_counter: illegal MinValue/MaxValue/InitValue for Digits");
  end
  state_t state;
  logic up_q, down_q, up_d, down_d, armed;
  logic dir, pend_v, pend_dir, changed;
  logic [W-1:0] count, stepped, next;
  logic [Digits:0] carry;
  logic up_edge, down_edge, req_v, req_dir, take_v, take_dir, at_max, at_min, limit;
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < Digits; i++) begin : g_digit
    bcd_digit_step u_step (
      .d(count[4*i +: 4]),
      .up(dir),
      .cin(carry[i]),
      .q(stepped[4*i +: 4]),
      .cout(carry[i+1])
    );
  end
  always_comb begin
    up_edge = up_q & ~up_d;
    down_edge = down_q & ~down_d;
    req_v = up_edge ^ down_edge;
    req_dir = up_edge;
    take_v = pend_v | req_v;
    take_dir = pend_v ? pend_dir : req_dir;
    at_max = count == MAX_BCD;
    at_min = count == MIN_BCD;
    limit = (dir ? at_max : at_min) | carry[Digits];
    next = !limit ? stepped : Wrap != 0 ? (dir ? MIN_BCD : MAX_BCD) : count;
  end
  // The first sample after reset seeds the edge history so a level held through reset never steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      up_q <= 1'b0;
      down_q <= 1'b0;
      up_d <= 1'b0;
      down_d <= 1'b0;
      armed <= 1'b0;
      dir <= 1'b0;
      pend_v <= 1'b0;
      pend_dir <= 1'b0;
      changed <= 1'b0;
      count <= INIT_BCD;
    end else begin
      up_q <= bus.up;
      down_q <= bus.down;
      up_d <= armed ? up_q : bus.up;
      down_d <= armed ? down_q : bus.down;
      armed <= 1'b1;
      changed <= 1'b0;
      if (state == STEP) begin
        count <= next;
        changed <= next != count;
        state <= next != count ? REPORT : IDLE;
        if (req_v) begin
          pend_v <= 1'b1;
          pend_dir <= req_dir;
        end
      end else if (take_v) begin
        state <= STEP;
        dir <= take_dir;
        pend_v <= pend_v & req_v;
        pend_dir <= req_dir;
      end else begin
        state <= IDLE;
      end
    end
  end
  assign bus.digits = count;
  assign bus.at_max = at_max;
  assign bus.at_min = at_min;
  assign bus.changed = changed;
endmodule
